// File: rtl/sayuru_mem_responder.sv
// Word-organised data RAM answering req/gnt/rvalid with programmable grant/rvalid latency.
// Optional MEM_RESP_ERR_EN: out-of-range word index reports data_err_o instead of aliasing.
module sayuru_mem_responder #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int GNT_DELAY    = 0,
  parameter int RVALID_DELAY = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);

  localparam int BEW = DATA_WIDTH / 8;
  localparam int IW  = $clog2(MEM_WORDS);
`ifdef MEM_RESP_ERR_EN
  localparam int XW  = ADDR_WIDTH - 2;
`else
  localparam int XW  = IW;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_WAIT,
    S_GRANT,
    S_DATA_WAIT,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_start;

  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic [XW-1:0]         r_idx;
  logic                  r_we;
  logic [BEW-1:0]        r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  w_err;
  logic [IW-1:0]         w_ram_idx;
  logic                  w_unused;

  assign w_unused  = ^data_addr_i;
  assign w_ram_idx = r_idx[IW-1:0];

`ifdef MEM_RESP_ERR_EN
  assign w_err = ({1'b0, r_idx} >= (XW+1)'(MEM_WORDS));
`else
  assign w_err = 1'b0;
`endif

  // A new request skips GNT_WAIT entirely when no grant delay is configured
  always_comb begin
    w_start = (GNT_DELAY == 0) ? S_GRANT : S_GNT_WAIT;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE, S_RESPOND: begin
        w_next = S_IDLE;
        if (data_req_i) begin
          w_next     = w_start;
          w_cnt_next = 4'(GNT_DELAY);
        end
      end
      S_GNT_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (!data_req_i) w_next = S_IDLE;
        else if (r_cnt == 4'd1) w_next = S_GRANT;
      end
      S_GRANT: begin
        w_cnt_next = 4'(RVALID_DELAY - 1);
        w_next     = (RVALID_DELAY == 1) ? S_RESPOND : S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESPOND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_GRANT) begin
      r_idx   <= data_addr_i[XW+1:2];
      r_we    <= data_we_i;
      r_be    <= data_be_i;
      r_wdata <= data_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_RESPOND && r_we && !w_err) begin
      for (int b = 0; b < BEW; b++) begin
        if (r_be[b]) r_mem[w_ram_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      read_count  <= 32'd0;
      write_count <= 32'd0;
    end else if (r_state == S_RESPOND) begin
      if (r_we) write_count <= write_count + 32'd1;
      else      read_count  <= read_count + 32'd1;
    end
  end

  always_comb begin
    data_gnt_o    = (r_state == S_GRANT);
    data_rvalid_o = (r_state == S_RESPOND);
    data_err_o    = data_rvalid_o & w_err;
    data_rdata_o  = '0;
    if (data_rvalid_o && !r_we) begin
      data_rdata_o = w_err ? DATA_WIDTH'(32'hDEAD_BEEF) : r_mem[w_ram_idx];
    end
  end

endmodule

// File: tb/tb_sayuru_mem_responder.sv
// Directed bench: fast (0/1) and slow (3/4) latency instances of sayuru_mem_responder.
module tb_sayuru_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;

  logic        gnt_f, rv_f, err_f, gnt_s, rv_s, err_s;
  logic [31:0] rd_f, rd_s, rc_f, wc_f, rc_s, wc_s;
  logic        w_gnt, w_rv, w_err;
  logic [31:0] w_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign w_gnt = sel ? gnt_s : gnt_f;
  assign w_rv  = sel ? rv_s  : rv_f;
  assign w_err = sel ? err_s : err_f;
  assign w_rd  = sel ? rd_s  : rd_f;

  sayuru_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(1)) u_fast (
    .clk_i(clk), .rst_i(rst), .data_req_i(req & ~sel),
    .data_gnt_o(gnt_f), .data_rvalid_o(rv_f), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rd_f), .data_err_o(err_f),
    .read_count(rc_f), .write_count(wc_f)
  );

  sayuru_mem_responder #(.GNT_DELAY(3), .RVALID_DELAY(4)) u_slow (
    .clk_i(clk), .rst_i(rst), .data_req_i(req & sel),
    .data_gnt_o(gnt_s), .data_rvalid_o(rv_s), .data_addr_i(addr),
    .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rd_s), .data_err_o(err_s),
    .read_count(rc_s), .write_count(wc_s)
  );

  // Runs one transaction on the selected instance; cycle 0 = first req cycle
  task automatic xact(input logic t_we, input logic [15:0] t_addr,
                      input logic [3:0] t_be, input logic [31:0] t_wd,
                      output int gc, output int rc, output int ng,
                      output logic [31:0] rdv, output logic erv);
    gc = -1; rc = -1; ng = 0; rdv = '0; erv = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wd;
    for (int c = 0; c < 40 && rc < 0; c++) begin
      @(negedge clk);
      if (w_gnt) begin ng++; gc = c; end
      if (w_rv) begin rc = c; rdv = w_rd; erv = w_err; end
      @(posedge clk); #1;
      if (gc >= 0) req = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_f, rv_f, err_f, gnt_s, rv_s, err_s} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {gnt_f, rv_f, err_f, gnt_s, rv_s, err_s});
    end
    checks++;
    if (rd_f !== 32'd0 || rd_s !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0", rd_f, rd_s);
    end
    checks++;
    if ({rc_f, wc_f, rc_s, wc_s} !== 128'd0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d/%0d/%0d exp=0", rc_f, wc_f, rc_s, wc_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int gc, rc, ng;
    logic [31:0] rdv;
    logic erv;
    sel = 1'b0;
    xact(1'b1, 16'h0040, 4'hF, 32'hCAFE_F00D, gc, rc, ng, rdv, erv);
    checks++;
    if (gc !== 1 || rc !== 2 || ng !== 1) begin
      failures++;
      $display("FAIL wr_timing got=g%0d r%0d n%0d exp=g1 r2 n1", gc, rc, ng);
    end
    checks++;
    if (rdv !== 32'd0) begin
      failures++;
      $display("FAIL wr_rdata got=%h exp=0", rdv);
    end
    xact(1'b0, 16'h0040, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (gc !== 1 || rc !== 2 || rdv !== 32'hCAFE_F00D || erv !== 1'b0) begin
      failures++;
      $display("FAIL rd_data got=g%0d r%0d %h e%b exp=g1 r2 cafef00d e0", gc, rc, rdv, erv);
    end
    @(negedge clk);
    checks++;
    if (rd_f !== 32'd0 || rv_f !== 1'b0) begin
      failures++;
      $display("FAIL rd_clear got=%h v%b exp=0 v0", rd_f, rv_f);
    end
    checks++;
    if (wc_f !== 32'd1 || rc_f !== 32'd1) begin
      failures++;
      $display("FAIL wr_rd_counts got=w%0d r%0d exp=w1 r1", wc_f, rc_f);
    end
  endtask

  task automatic test_byte_enable;
    int gc, rc, ng;
    logic [31:0] rdv;
    logic erv;
    sel = 1'b0;
    xact(1'b1, 16'h0010, 4'hF, 32'h1122_3344, gc, rc, ng, rdv, erv);
    xact(1'b1, 16'h0010, 4'b0101, 32'hAABB_CCDD, gc, rc, ng, rdv, erv);
    xact(1'b0, 16'h0010, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL be_merge got=%h exp=11bb33dd", rdv);
    end
    xact(1'b1, 16'h0010, 4'h0, 32'hFFFF_FFFF, gc, rc, ng, rdv, erv);
    checks++;
    if (rc !== 2) begin
      failures++;
      $display("FAIL be0_rvalid got=%0d exp=2", rc);
    end
    xact(1'b0, 16'h0010, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL be0_nochange got=%h exp=11bb33dd", rdv);
    end
    checks++;
    if (wc_f !== 32'd4 || rc_f !== 32'd3) begin
      failures++;
      $display("FAIL be_counts got=w%0d r%0d exp=w4 r3", wc_f, rc_f);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] eg;
    logic [5:0] ev;
    eg = 6'b001010;
    ev = 6'b010100;
    sel = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 16'h0040;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_f !== eg[c] || rv_f !== ev[c]) begin
        failures++;
        $display("FAIL b2b_c%0d got=g%b v%b exp=g%b v%b", c, gnt_f, rv_f, eg[c], ev[c]);
      end
      if (c == 2 && rd_f !== 32'hCAFE_F00D) begin
        failures++;
        $display("FAIL b2b_data0 got=%h exp=cafef00d", rd_f);
      end
      if (c == 4 && rd_f !== 32'h11BB_33DD) begin
        failures++;
        $display("FAIL b2b_data1 got=%h exp=11bb33dd", rd_f);
      end
      @(posedge clk); #1;
      if (c == 1) addr = 16'h0010;
      if (c == 3) req = 1'b0;
    end
    checks++;
    if (rc_f !== 32'd5) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=5", rc_f);
    end
  endtask

  task automatic test_latency;
    int gc, rc, ng, nr;
    logic [31:0] rdv;
    logic erv;
    sel = 1'b1;
    xact(1'b1, 16'h0020, 4'hF, 32'h5A5A_1234, gc, rc, ng, rdv, erv);
    checks++;
    if (gc !== 4 || rc !== 8 || ng !== 1) begin
      failures++;
      $display("FAIL lat_wr got=g%0d r%0d n%0d exp=g4 r8 n1", gc, rc, ng);
    end
    xact(1'b0, 16'h0020, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (gc !== 4 || rc !== 8 || rdv !== 32'h5A5A_1234) begin
      failures++;
      $display("FAIL lat_rd got=g%0d r%0d %h exp=g4 r8 5a5a1234", gc, rc, rdv);
    end
    ng = 0; nr = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (gnt_s) ng++;
      if (rv_s) nr++;
      @(posedge clk); #1;
      if (c == 1) req = 1'b0;
    end
    checks++;
    if (ng !== 0 || nr !== 0) begin
      failures++;
      $display("FAIL abort got=g%0d v%0d exp=g0 v0", ng, nr);
    end
    checks++;
    if (wc_s !== 32'd1 || rc_s !== 32'd1) begin
      failures++;
      $display("FAIL abort_counts got=w%0d r%0d exp=w1 r1", wc_s, rc_s);
    end
  endtask

  task automatic test_reset_mid_op;
    int gc, rc, ng, nr;
    logic [31:0] rdv;
    logic erv;
    sel = 1'b1;
    ng = 0; nr = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h0020; be = 4'hF; wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt_s) ng++;
      if (rv_s) nr++;
      @(posedge clk); #1;
      if (c == 4) begin req = 1'b0; rst = 1'b1; end
      if (c == 5) rst = 1'b0;
    end
    checks++;
    if (ng !== 1 || nr !== 0) begin
      failures++;
      $display("FAIL rst_mid got=g%0d v%0d exp=g1 v0", ng, nr);
    end
    checks++;
    if (wc_s !== 32'd0 || rc_s !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_counts got=w%0d r%0d exp=0", wc_s, rc_s);
    end
    xact(1'b0, 16'h0020, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h5A5A_1234 || rc !== 8) begin
      failures++;
      $display("FAIL rst_mid_ram got=%h r%0d exp=5a5a1234 r8", rdv, rc);
    end
    checks++;
    if (rc_s !== 32'd1) begin
      failures++;
      $display("FAIL rst_mid_rdcount got=%0d exp=1", rc_s);
    end
  endtask

  task automatic test_addr_err;
    int gc, rc, ng;
    logic [31:0] rdv;
    logic erv;
    sel = 1'b0;
    xact(1'b1, 16'h0000, 4'hF, 32'h0BAD_F00D, gc, rc, ng, rdv, erv);
`ifdef MEM_RESP_ERR_EN
    xact(1'b0, 16'h1000, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'hDEAD_BEEF || erv !== 1'b1) begin
      failures++;
      $display("FAIL err_rd got=%h e%b exp=deadbeef e1", rdv, erv);
    end
    xact(1'b1, 16'h1000, 4'hF, 32'hFFFF_FFFF, gc, rc, ng, rdv, erv);
    checks++;
    if (erv !== 1'b1 || rc !== 2) begin
      failures++;
      $display("FAIL err_wr got=e%b r%0d exp=e1 r2", erv, rc);
    end
    xact(1'b0, 16'h0000, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h0BAD_F00D || erv !== 1'b0) begin
      failures++;
      $display("FAIL err_word0 got=%h e%b exp=0badf00d e0", rdv, erv);
    end
`else
    xact(1'b0, 16'h1000, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h0BAD_F00D || erv !== 1'b0) begin
      failures++;
      $display("FAIL alias_rd got=%h e%b exp=0badf00d e0", rdv, erv);
    end
    xact(1'b1, 16'h1000, 4'b0001, 32'h0000_0077, gc, rc, ng, rdv, erv);
    xact(1'b0, 16'h0000, 4'h0, 32'd0, gc, rc, ng, rdv, erv);
    checks++;
    if (rdv !== 32'h0BAD_F077 || erv !== 1'b0) begin
      failures++;
      $display("FAIL alias_wr got=%h e%b exp=0badf077 e0", rdv, erv);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_enable;
    test_back_to_back;
    test_latency;
    test_reset_mid_op;
    test_addr_err;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
